perceptron_sequencer: RTL and testbench
=======================================

# perceptron_sequencer

Sequencer that drives one combinational `perceptron` datapath through a full neuron evaluation. It streams up to 2^ADDR_W activation/weight pairs from a synchronous memory, accumulates them in an internal 24-bit register, and then issues one activation pass. The block sits between the layer controller, which supplies start, count and bias, and the shared perceptron/memory pair.

## Interface
Parameters:
- ADDR_W, 8, memory address width; max inputs per neuron = 2^ADDR_W

Ports:
- clk  in  1  clock. Single clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a neuron evaluation. Accepted only in IDLE.
- n_inputs  in  ADDR_W+1  number of input pairs. Sampled with start. Legal range 0..2^ADDR_W.
- bias  in  24  initial accumulator value. Sampled with start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- a_data  in  24  activation read data, valid 1 cycle after rd_en.
- w_data  in  16  weight read data, valid 1 cycle after rd_en.
- p_a  out  24  to perceptron a (equal to a_data).
- p_b  out  16  to perceptron b (equal to w_data).
- p_x  out  24  to perceptron x (accumulator register).
- p_stop  out  1  to perceptron stop.
- p_acti  out  1  to perceptron acti_en.
- p_out  in  24  from perceptron out.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  24  activated neuron output. Held until the next done.

## Operation
- States: IDLE, RUN, DRAIN, ACT.
- IDLE, on start:
  - acc<=bias, idx<=0, cnt<=n_inputs.
  - Next state RUN if n_inputs!=0, else ACT.
- IDLE, no start: no state change.
- RUN:
  - rd_en=1, rd_addr=idx[ADDR_W-1:0], idx<=idx+1.
  - When idx==cnt-1, next state is DRAIN.
- dvalid: register holding rd_en delayed by one cycle.
- When dvalid=1: p_stop=0 and acc<=p_out, which equals acc+mul(a_data,w_data).
- DRAIN: rd_en=0. Consumes the final data beat (dvalid=1). Next state ACT.
- ACT:
  - p_stop=1, p_acti=1, result<=p_out, done<=1 on the next cycle.
  - Next state IDLE.
- p_stop=1 in every cycle with dvalid=0, so the perceptron passes x through unchanged.
- p_acti=0 outside ACT.
- p_x=acc at all times.
- Arithmetic:
  - Accumulation wraps modulo 2^24 exactly as the perceptron sums. The sequencer adds no saturation.
  - The activation output's sign extension and LSB padding come from the perceptron.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as the done pulse (state IDLE) is accepted. This gives back-to-back neurons with no gap beyond the IDLE cycle.
- n_inputs values above 2^ADDR_W are illegal; behaviour is unspecified.

## Timing
- Reset values:
  - state=IDLE, acc=0, idx=0, cnt=0, dvalid=0, result=0.
  - done=0, busy=0, rd_en=0, rd_addr=0, p_stop=1, p_acti=0.
- Cycle numbering: start is sampled at the edge ending cycle 0.
- RUN occupies cycles 1..N. Address k is issued in cycle k+1.
- Data for address k arrives in cycle k+2 and is accumulated at the end of that cycle.
- DRAIN is cycle N+1; ACT is cycle N+2; done=1 and result valid in cycle N+3.
- Start-to-done latency is N+3 cycles; for N=0 it is 2 cycles (ACT in cycle 1, done in cycle 2).
- busy is high in cycles 1..N+2 and low in the done cycle.
- rst mid-operation: everything returns to reset values on the next edge.
  - Any in-flight read data is discarded (dvalid cleared).
  - result clears to 0.
- rst has priority over start in the same cycle.

## Test plan
- N=3, bias=0, memory holds pairs (a,w) at addresses 0..2 -> rd_addr 0,1,2 in cycles 1..3; done in cycle 6; result=activation(sum of mul terms) matching the bench model of multiplication/actifunction.
- N=0, bias=0x001000 -> no rd_en pulse; done in cycle 2; result=activation(0x001000).
- N=2^ADDR_W (256), all w=0, bias=B -> addresses 0..255 then stop (no wrap to 0); done in cycle 259; result=activation(B).
- start pulsed again in cycles 1..4 of an N=4 run -> ignored; exactly one done, in cycle 7.
- rst asserted in cycle 2 of an N=5 run -> the next cycle shows all outputs at reset values and no done; a following start with N=1 completes normally in 4 cycles.
- Back-to-back: second start in the first run's done cycle (N=2 then N=1) -> second done exactly 4 cycles later; the first result is held until then.

Source files
------------

// File: rtl/perceptron_sequencer.sv
// Sequencer that walks one neuron through a shared perceptron: it streams activation/weight
// pairs from a synchronous memory into a 24-bit accumulator, then runs one activation pass.
module perceptron_sequencer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   n_inputs,
   input  logic [23:0]       bias,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       a_data,
   input  logic [15:0]       w_data,
   output logic [23:0]       p_a,
   output logic [15:0]       p_b,
   output logic [23:0]       p_x,
   output logic              p_stop,
   output logic              p_acti,
   input  logic [23:0]       p_out,
   output logic              busy,
   output logic              done,
   output logic [23:0]       result
);

   // Handshake: start is taken only in IDLE (busy=0) and ignored otherwise; done is a
   // single-cycle pulse with result valid that cycle, and result holds until the next done.

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ACT} state_t;

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state, state_nxt;
   logic [ADDR_W:0] idx, cnt;
   logic [23:0]     acc;
   logic            dvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         idx    <= '0;
         cnt    <= '0;
         dvalid <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         dvalid <= (state == RUN);
         done   <= (state == ACT);
         if (state == IDLE && start) begin
            acc <= bias;
            idx <= '0;
            cnt <= n_inputs;
         end else begin
            // The perceptron already forms acc + a*w while a data beat is present.
            if (dvalid) acc <= p_out;
            if (state == RUN) idx <= idx + ONE;
         end
         if (state == ACT) result <= p_out;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      p_acti    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (n_inputs != '0) ? RUN : ACT;
         end
         RUN: begin
            rd_en   = 1'b1;
            rd_addr = idx[ADDR_W-1:0];
            // Compare on the full width so a 2^ADDR_W count stops after the last address.
            if (idx == cnt - ONE) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = ACT;
         ACT: begin
            p_acti    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign p_a    = a_data;
   assign p_b    = w_data;
   assign p_x    = acc;
   assign p_stop = ~dvalid;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Directed bench for perceptron_sequencer with a synchronous memory model and a simple
// perceptron model (mul = signed a*w >>> 8, activation = ReLU).
module tb_perceptron_sequencer;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   n_inputs;
   logic [23:0]       bias;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [23:0]       a_data;
   logic [15:0]       w_data;
   logic [23:0]       p_a;
   logic [15:0]       p_b;
   logic [23:0]       p_x;
   logic              p_stop;
   logic              p_acti;
   logic [23:0]       p_out;
   logic              busy;
   logic              done;
   logic [23:0]       result;

   logic [23:0] mem_a [0:(1<<ADDR_W)-1];
   logic [15:0] mem_w [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;

   perceptron_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_inputs(n_inputs), .bias(bias),
      .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .w_data(w_data),
      .p_a(p_a), .p_b(p_b), .p_x(p_x), .p_stop(p_stop), .p_acti(p_acti),
      .p_out(p_out), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data valid one cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= mem_a[rd_addr];
         w_data <= mem_w[rd_addr];
      end
   end

   function automatic logic [23:0] mul(input logic [23:0] a, input logic [15:0] w);
      logic signed [39:0] p;
      p = $signed(a) * $signed(w);
      return p[31:8];
   endfunction

   function automatic logic [23:0] acti(input logic [23:0] x);
      return x[23] ? 24'h0 : x;
   endfunction

   assign p_out = p_stop ? (p_acti ? acti(p_x) : p_x) : p_x + mul(p_a, p_b);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < (1<<ADDR_W); i++) begin
         mem_a[i] = 24'h0;
         mem_w[i] = 16'h0;
      end
   endtask

   task automatic issue(input int n, input logic [23:0] b);
      start    = 1'b1;
      n_inputs = n[ADDR_W:0];
      bias     = b;
   endtask

   initial begin
      int done_cnt;
      rst = 1'b1; start = 1'b0; n_inputs = '0; bias = '0;
      a_data = '0; w_data = '0;
      clear_mem();
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_p_stop", p_stop, 1);
      chk("rst_p_acti", p_acti, 0);
      chk("rst_result", result, 0);
      chk("rst_p_x", p_x, 0);
      rst = 1'b0;
      tick();

      // N=3: terms 3 + 10 + (-4) = 9
      mem_a[0] = 24'h000100; mem_w[0] = 16'd3;
      mem_a[1] = 24'h000200; mem_w[1] = 16'd5;
      mem_a[2] = 24'h000400; mem_w[2] = 16'hFFFF;
      issue(3, 24'h0);
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
         if (c <= 3) begin
            chk($sformatf("n3_rd_en_c%0d", c), rd_en, 1);
            chk($sformatf("n3_rd_addr_c%0d", c), rd_addr, c - 1);
         end else begin
            chk($sformatf("n3_rd_idle_c%0d", c), rd_en, 0);
         end
         chk($sformatf("n3_busy_c%0d", c), busy, (c <= 5));
         chk($sformatf("n3_acti_c%0d", c), p_acti, (c == 5));
         chk($sformatf("n3_done_c%0d", c), done, (c == 6));
      end
      chk("n3_result", result, 24'h000009);

      // N=0 positive bias passes through the activation
      issue(0, 24'h001000);
      for (int c = 1; c <= 2; c++) begin
         tick();
         start = 1'b0;
         chk($sformatf("n0_rd_en_c%0d", c), rd_en, 0);
         chk($sformatf("n0_done_c%0d", c), done, (c == 2));
      end
      chk("n0_result", result, 24'h001000);

      // N=0 negative bias is clamped by ReLU
      issue(0, 24'hFFF000);
      tick(); start = 1'b0; tick();
      chk("n0neg_done", done, 1);
      chk("n0neg_result", result, 24'h000000);

      // N=256 with zero weights: addresses 0..255, no wrap
      clear_mem();
      for (int i = 0; i < 256; i++) mem_a[i] = 24'h7FFFFF;
      issue(256, 24'h012345);
      for (int c = 1; c <= 259; c++) begin
         tick();
         start = 1'b0;
         if (c <= 256) begin
            if (rd_en !== 1'b1 || rd_addr !== c - 1) begin
               chk($sformatf("n256_addr_c%0d", c), {rd_en, rd_addr}, {1'b1, 8'(c - 1)});
            end
         end
         if (c == 257) chk("n256_no_wrap", rd_en, 0);
         if (done !== (c == 259)) chk($sformatf("n256_done_c%0d", c), done, (c == 259));
      end
      chk("n256_addr_last", 32'(dut.rd_addr), 0);
      chk("n256_done", done, 1);
      chk("n256_result", result, 24'h012345);

      // start held through cycles 1..4 of an N=4 run is ignored
      mem_a[0] = 24'h000100; mem_w[0] = 16'd3;
      issue(4, 24'h0);
      done_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 5) start = 1'b0;
         if (done) begin
            done_cnt++;
            chk("ign_done_cycle", c, 7);
         end
      end
      chk("ign_done_count", done_cnt, 1);
      chk("ign_result", result, 24'h000003);

      // rst in cycle 2 of an N=5 run
      issue(5, 24'h000050);
      tick(); start = 1'b0;
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_rd_en", rd_en, 0);
      chk("mrst_rd_addr", rd_addr, 0);
      chk("mrst_p_stop", p_stop, 1);
      chk("mrst_p_acti", p_acti, 0);
      chk("mrst_result", result, 0);
      chk("mrst_p_x", p_x, 0);
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("mrst_no_done", done_cnt, 0);
      issue(1, 24'h000010);
      for (int c = 1; c <= 4; c++) begin
         tick();
         start = 1'b0;
         chk($sformatf("mrst_n1_done_c%0d", c), done, (c == 4));
      end
      chk("mrst_n1_result", result, 24'h000013);

      // back-to-back: N=2 then N=1 started in the first done cycle
      mem_a[1] = 24'h000200; mem_w[1] = 16'd5;
      issue(2, 24'h000100);
      for (int c = 1; c <= 5; c++) begin
         tick();
         start = 1'b0;
         if (c < 5) chk($sformatf("b2b_first_done_c%0d", c), done, 0);
      end
      chk("b2b_first_done", done, 1);
      chk("b2b_first_result", result, 24'h00010D);
      chk("b2b_idle_at_done", busy, 0);
      issue(1, 24'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         start = 1'b0;
         chk($sformatf("b2b_second_done_c%0d", c), done, (c == 4));
         if (c < 4) chk($sformatf("b2b_hold_c%0d", c), result, 24'h00010D);
      end
      chk("b2b_second_result", result, 24'h000003);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
